cb_filter_banked: RTL

CB_FILTER_BANKED -- requirements
Module: cb_filter_banked

---
 rtl/cb_filter_pkg.sv | 27 ++
 rtl/cb_hash.sv | 42 ++++
 rtl/cb_filter_banked.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cb_filter_pkg.sv
// cb_filter_pkg: shared types and constants for the counting bloom filter.
//   cb_seed_t   - per-hash seed: rotate amount (bit permutation) and XOR mask
//   cb_state_e  - clear FSM state encoding
//   CbSeeds1..4 - example seed sets for 1 to 4 hash functions
package cb_filter_pkg;

  typedef struct packed {
    logic [7:0]  rot;  // left-rotate amount applied to the key (mod key width)
    logic [31:0] xr;   // XOR mask, repeated every 32 bits across the key
  } cb_seed_t;

  typedef enum logic {
    CB_IDLE  = 1'b0,
    CB_CLEAR = 1'b1
  } cb_state_e;

  localparam cb_seed_t CbSeedA = '{rot: 8'd0, xr: 32'h0000_0000};
  localparam cb_seed_t CbSeedB = '{rot: 8'd1, xr: 32'hA5A5_A5A5};
  localparam cb_seed_t CbSeedC = '{rot: 8'd3, xr: 32'h3C3C_3C3C};
  localparam cb_seed_t CbSeedD = '{rot: 8'd5, xr: 32'h0F1E_2D4B};

  localparam cb_seed_t [0:0] CbSeeds1 = {CbSeedA};
  localparam cb_seed_t [1:0] CbSeeds2 = {CbSeedB, CbSeedA};
  localparam cb_seed_t [2:0] CbSeeds3 = {CbSeedC, CbSeedB, CbSeedA};
  localparam cb_seed_t [3:0] CbSeeds4 = {CbSeedD, CbSeedC, CbSeedB, CbSeedA};

endpackage

// File: rtl/cb_hash.sv
// cb_hash: maps one key to a one-hot-union bucket mask.
//   Each of NumHashes functions rotates the key, XORs in its seed and
//   XOR-folds the result down to HashWidth bits; the resulting indices are
//   OR-ed into mask_o, so duplicate indices set a single bit.
// Ports:
//   key_i  [KeyWidth]     - key to hash
//   mask_o [2**HashWidth] - set of buckets touched by the key
module cb_hash
  import cb_filter_pkg::*;
#(
  parameter int                          KeyWidth  = 32,
  parameter int                          HashWidth = 6,
  parameter int                          NumHashes = 3,
  parameter cb_seed_t [NumHashes-1:0]    Seeds     = CbSeeds4[NumHashes-1:0]
) (
  input  logic [KeyWidth-1:0]       key_i,
  output logic [2**HashWidth-1:0]   mask_o
);

  logic [KeyWidth-1:0]  perm;
  logic [HashWidth-1:0] idx;

  always_comb begin
    mask_o = '0;
    perm   = '0;
    idx    = '0;
    for (int h = 0; h < NumHashes; h++) begin
      perm = '0;
      idx  = '0;
      // Rotate left by rot: output bit i takes key bit (i - rot) mod KeyWidth.
      for (int i = 0; i < KeyWidth; i++) begin
        perm[i] = key_i[(i + KeyWidth - (int'(Seeds[h].rot) % KeyWidth)) % KeyWidth]
                  ^ Seeds[h].xr[i % 32];
      end
      for (int i = 0; i < KeyWidth; i++) begin
        idx[i % HashWidth] = idx[i % HashWidth] ^ perm[i];
      end
      mask_o[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cb_filter_banked.sv
// cb_filter_banked: counting bloom filter with 2**HashWidth saturating
// bucket counters.
//   look_data_i / look_hit_o     - combinational membership query
//   incr_data_i / incr_valid_i   - insert a key (bucket counters +1)
//   decr_data_i / decr_valid_i   - remove a key (bucket counters -1)
//   clear_i                      - start a one-bucket-per-cycle clear walk
//   ready_o                      - incr/decr accepted this cycle
//   usage_o / full_o / empty_o   - registered occupancy of non-zero buckets
//   error_o                      - sticky overflow/underflow flag
// Build option: define CB_FILTER_CLEAR_EN to build the clear FSM. Without it
// clear_i is ignored, ready_o is tied high and error_o clears only on reset.
module cb_filter_banked
  import cb_filter_pkg::*;
#(
  parameter int                       KeyWidth  = 32,
  parameter int                       CntWidth  = 4,
  parameter int                       HashWidth = 6,
  parameter int                       NumHashes = 3,
  parameter cb_seed_t [NumHashes-1:0] Seeds     = CbSeeds4[NumHashes-1:0]
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [KeyWidth-1:0]  look_data_i,
  output logic                 look_hit_o,
  input  logic [KeyWidth-1:0]  incr_data_i,
  input  logic                 incr_valid_i,
  input  logic [KeyWidth-1:0]  decr_data_i,
  input  logic                 decr_valid_i,
  input  logic                 clear_i,
  output logic                 ready_o,
  output logic [HashWidth:0]   usage_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 error_o
);

  localparam int                NumBuckets = 2**HashWidth;
  localparam logic [CntWidth-1:0] CntMax   = '1;

  logic [CntWidth-1:0]   cnt_q [NumBuckets];
  logic [CntWidth-1:0]   cnt_d [NumBuckets];
  logic [NumBuckets-1:0] look_mask, incr_mask, decr_mask;
  logic [NumBuckets-1:0] nz_q, nz_d;
  logic [HashWidth:0]    usage_q, usage_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  error_q, error_d;
  logic                  ready, clr_act, clr_done;
  logic [HashWidth-1:0]  clr_idx;
  logic                  inc_en, dec_en, ovf_udf;

  cb_hash #(.KeyWidth(KeyWidth), .HashWidth(HashWidth), .NumHashes(NumHashes), .Seeds(Seeds))
    u_hash_look (.key_i(look_data_i), .mask_o(look_mask));
  cb_hash #(.KeyWidth(KeyWidth), .HashWidth(HashWidth), .NumHashes(NumHashes), .Seeds(Seeds))
    u_hash_incr (.key_i(incr_data_i), .mask_o(incr_mask));
  cb_hash #(.KeyWidth(KeyWidth), .HashWidth(HashWidth), .NumHashes(NumHashes), .Seeds(Seeds))
    u_hash_decr (.key_i(decr_data_i), .mask_o(decr_mask));

`ifdef CB_FILTER_CLEAR_EN
  cb_state_e            state_q, state_d;
  logic [HashWidth-1:0] idx_q, idx_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_done = 1'b0;
    unique case (state_q)
      CB_IDLE: begin
        if (clear_i) begin
          state_d = CB_CLEAR;
          idx_d   = '0;
        end
      end
      CB_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d  = CB_IDLE;
          clr_done = 1'b1;
        end
      end
      default: state_d = CB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CB_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign ready   = (state_q == CB_IDLE);
  assign clr_act = (state_q == CB_CLEAR);
  assign clr_idx = idx_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign ready        = 1'b1;
  assign clr_act      = 1'b0;
  assign clr_idx      = '0;
  assign clr_done     = 1'b0;
`endif

  assign inc_en = incr_valid_i & ready;
  assign dec_en = decr_valid_i & ready;

  // Bucket update. A bucket hit by both incr and decr in one cycle is left
  // alone, so it can neither overflow nor underflow.
  always_comb begin
    ovf_udf = 1'b0;
    nz_d    = '0;
    for (int b = 0; b < NumBuckets; b++) begin
      cnt_d[b] = cnt_q[b];
      if (clr_act && (clr_idx == HashWidth'(b))) begin
        cnt_d[b] = '0;
      end else if (inc_en && incr_mask[b] && !(dec_en && decr_mask[b])) begin
        if (cnt_q[b] == CntMax) ovf_udf = 1'b1;
        else                    cnt_d[b] = cnt_q[b] + 1'b1;
      end else if (dec_en && decr_mask[b] && !(inc_en && incr_mask[b])) begin
        if (cnt_q[b] == '0) ovf_udf = 1'b1;
        else                cnt_d[b] = cnt_q[b] - 1'b1;
      end
      nz_d[b] = (cnt_d[b] != '0);
    end
  end

  // Occupancy is computed from next-state buckets so the registered flags
  // always agree with the registered buckets.
  always_comb begin
    usage_d = '0;
    for (int b = 0; b < NumBuckets; b++) begin
      usage_d = usage_d + (HashWidth+1)'(nz_d[b]);
    end
    full_d  = (usage_d == (HashWidth+1)'(NumBuckets));
    empty_d = (usage_d == '0);
    error_d = clr_done ? 1'b0 : (error_q | ovf_udf);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBuckets; b++) cnt_q[b] <= '0;
      usage_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      for (int b = 0; b < NumBuckets; b++) cnt_q[b] <= cnt_d[b];
      usage_q <= usage_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    for (int b = 0; b < NumBuckets; b++) nz_q[b] = (cnt_q[b] != '0);
  end

  assign look_hit_o = &(nz_q | ~look_mask);
  assign ready_o    = ready;
  assign usage_o    = usage_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign error_o    = error_q;

endmodule
